wb_commit_stage: RTL and testbench
==================================

// Module: wb_commit_stage
// PURPOSE
//  Writeback stage with its own MEM/WB stage register.
//  - Selects ALU result, load data or link address; aligns and extends sub-word loads.
//  - Waits a variable number of cycles for load data; the stage stalls upstream while it waits.
//  - Drives the register-file write port and the forwarding/hazard bus. Sits between the MEM stage and the regfile.
// PARAMETERS
//  XLEN     32  datapath width; legal values 32 and 64
//  REG_AW   5   register address width
//  CNT_W    32  retire counter width; used only with WB_PERF_CNT_EN
// PORTS
//  clk           in   1        clock; all state changes on the rising edge
//  rst_n         in   1        asynchronous active-low reset
//  flush         in   1        synchronous kill of the in-flight load and of the incoming capture
//  in_valid      in   1        MEM stage offers an instruction
//  in_ready      out  1        stage can accept an instruction
//  in_wb_sel     in   2        00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
//  in_reg_we     in   1        instruction writes a register
//  in_reg_addr   in   REG_AW   destination register
//  in_alu_result in   XLEN     ALU result
//  in_link_addr  in   XLEN     return address for link instructions
//  in_mem_op     in   3        000 full word, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 treated as full word
//  in_byte_off   in   $clog2(XLEN/8)  low address bits of the load
//  mem_rvalid    in   1        load data valid; one pulse per issued load
//  mem_rdata     in   XLEN     raw load data word
//  rf_we         out  1        regfile write enable
//  rf_waddr      out  REG_AW   regfile write address
//  rf_wdata      out  XLEN     regfile write data
//  fwd_pending   out  1        load in WAIT_MEM targets fwd_addr; hazard unit must stall
//  fwd_valid     out  1        fwd_data is valid for fwd_addr
//  fwd_addr      out  REG_AW   destination of the held instruction
//  fwd_data      out  XLEN     write data of the held instruction
//  retire        out  1        one-cycle pulse per committed instruction
//  perf_retired  out  CNT_W    retired-instruction count; exists only with WB_PERF_CNT_EN
// BEHAVIOUR
//  - States: EMPTY, WAIT_MEM, COMMIT, DRAIN.
//  - Reset: state = EMPTY; every output and the stage register = 0 (in_ready = 1 in EMPTY).
//  - in_ready = (state == EMPTY || state == COMMIT). Capture happens when in_valid && in_ready && !flush.
//  - Transitions on capture: wb_sel == MEM goes to WAIT_MEM; any other wb_sel goes to COMMIT.
//  - COMMIT with no capture goes to EMPTY. COMMIT with a capture loads the new instruction, so back-to-back gives one instruction per cycle.
//  - WAIT_MEM: when mem_rvalid = 1, the aligned data is latched and the state goes to COMMIT.
//  - Latency: a non-load is committed the cycle after capture. A load is committed the cycle after mem_rvalid, minimum 2 cycles.
//  - COMMIT is one cycle. In it: rf_we = reg_we && (addr != 0); retire = 1; fwd_valid = rf_we.
//  - Writes to r0 are suppressed but still retire.
//  - fwd_pending = (state == WAIT_MEM && reg_we && addr != 0).
//  - fwd_addr / fwd_data are only meaningful while fwd_valid or fwd_pending is high.
//  - Load alignment is little-endian.
//    - LB/LBU: byte = rdata[8*off +: 8].
//    - LH/LHU: halfword at off with bit 0 ignored.
//    - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; full word passes rdata unchanged.
//  - flush has priority over in_valid.
//    - In WAIT_MEM: if mem_rvalid is also high that cycle, go to EMPTY; otherwise go to DRAIN. No commit either way.
//    - In COMMIT: the held instruction still commits; the capture is suppressed and the state goes to EMPTY.
//  - DRAIN: in_ready = 0. Waits for the orphan mem_rvalid, discards its data, then goes to EMPTY.
//  - mem_rvalid in EMPTY or COMMIT is ignored.
//  - Reset mid-WAIT_MEM drops the load. Memory must not return data after reset.
// CONFIGURATION
//  - WB_PERF_CNT_EN defined: perf_retired increments on every retire pulse.
//    - Wraps modulo 2^CNT_W; reset value 0.
//  - WB_PERF_CNT_EN undefined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package wb_pkg holds:
//    - the wb_sel encodings WB_SEL_ALU/MEM/LINK;
//    - the mem_op encodings MOP_WORD/LB/LBU/LH/LHU;
//    - the state enum wb_state_t.
//  - Sub-module wb_load_align: combinational extraction and extension from (mem_rdata, mem_op, byte_off) to XLEN.
//  - This module holds the FSM, the stage register and the optional counter.
// TESTING
//  - ALU op: in_wb_sel=00, addr=5, alu=32'h1234 -> next cycle rf_we=1, waddr=5, wdata=32'h1234, retire=1.
//  - LB with stall:
//    - rdata=32'h80FF7F01, off=3, 3-cycle mem latency -> in_ready=0 and fwd_pending=1 for 3 cycles.
//    - Then wdata=32'hFFFFFF80.
//  - Sub-word extension on rdata=32'h80FF7F01:
//    - LHU off=2 -> 32'h000080FF.
//    - LH off=2 -> 32'hFFFF80FF.
//    - LBU off=1 -> 32'h0000007F.
//  - Back-to-back: 4 ALU ops with in_valid held high -> 4 consecutive rf_we pulses; JAL addr=31 writes link value.
//  - r0: write to addr=0 -> rf_we=0, retire=1.
//  - Flush:
//    - flush during WAIT_MEM, rvalid 2 cycles later -> no commit, DRAIN state, then next load commits its own data.
//    - With WB_PERF_CNT_EN: perf_retired counts only committed instructions.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings and state type for the writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    // Load width / extension select
    localparam logic [2:0] MOP_WORD = 3'b000;
    localparam logic [2:0] MOP_LB   = 3'b001;
    localparam logic [2:0] MOP_LBU  = 3'b010;
    localparam logic [2:0] MOP_LH   = 3'b011;
    localparam logic [2:0] MOP_LHU  = 3'b100;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2,
        DRAIN    = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Extracts a byte/halfword from the raw load word (little-endian) and extends it to XLEN.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [2:0]       memOp,
    input  logic [OFF_W-1:0] byteOff,
    output logic [XLEN-1:0]  result
);

    logic [OFF_W-1:0] halfOff;
    logic [7:0]       byteVal;
    logic [15:0]      halfVal;

    // Pick the addressed lane, then sign- or zero-extend by op; halfword ignores offset bit 0
    always_comb begin
        halfOff = byteOff & ~OFF_W'(1);
        byteVal = rdata[8*byteOff +: 8];
        halfVal = rdata[8*halfOff +: 16];
        case (memOp)
            MOP_LB:  result = {{(XLEN-8){byteVal[7]}}, byteVal};
            MOP_LBU: result = {{(XLEN-8){1'b0}}, byteVal};
            MOP_LH:  result = {{(XLEN-16){halfVal[15]}}, halfVal};
            MOP_LHU: result = {{(XLEN-16){1'b0}}, halfVal};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback stage: MEM/WB register, load wait/align, regfile write and forwarding bus. Optional retire counter under WB_PERF_CNT_EN.
// Latency: non-load commits 1 cycle after capture; load commits 1 cycle after mem_rvalid (min 2).
// Backpressure: in_ready low while waiting for or draining load data; one instruction per cycle otherwise.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_wb_sel,
    input  logic                         in_reg_we,
    input  logic [REG_AW-1:0]            in_reg_addr,
    input  logic [XLEN-1:0]              in_alu_result,
    input  logic [XLEN-1:0]              in_link_addr,
    input  logic [2:0]                   in_mem_op,
    input  logic [$clog2(XLEN/8)-1:0]    in_byte_off,
    input  logic                         mem_rvalid,
    input  logic [XLEN-1:0]              mem_rdata,
    output logic                         rf_we,
    output logic [REG_AW-1:0]            rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic                         fwd_pending,
    output logic                         fwd_valid,
    output logic [REG_AW-1:0]            fwd_addr,
    output logic [XLEN-1:0]              fwd_data,
    output logic                         retire
`ifdef WB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]             perf_retired
`endif
);

    localparam int OFF_W = $clog2(XLEN / 8);

    if (XLEN != 32 && XLEN != 64) begin : gBadXlen
        $error("wb_commit_stage: XLEN must be 32 or 64");
    end
    if (CNT_W < 1) begin : gBadCnt
        $error("wb_commit_stage: CNT_W must be at least 1");
    end

    wb_state_t         state, nextState;
    logic              capture, loadLatch, destLive;
    logic              stgWe;
    logic [REG_AW-1:0] stgAddr;
    logic [2:0]        stgOp;
    logic [OFF_W-1:0]  stgOff;
    logic [XLEN-1:0]   stgData;
    logic [XLEN-1:0]   alignedData;

    wb_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) uAlign (
        .rdata   (mem_rdata),
        .memOp   (stgOp),
        .byteOff (stgOff),
        .result  (alignedData)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= nextState;
    end

    // Next state and all stage outputs; flush wins over a new capture
    always_comb begin
        nextState   = state;
        in_ready    = (state == EMPTY) || (state == COMMIT);
        capture     = in_valid && in_ready && !flush;
        loadLatch   = 1'b0;
        destLive    = stgWe && (stgAddr != '0);
        rf_we       = 1'b0;
        retire      = 1'b0;
        fwd_pending = 1'b0;
        case (state)
            EMPTY, COMMIT: begin
                if (capture) nextState = (in_wb_sel == WB_SEL_MEM) ? WAIT_MEM : COMMIT;
                else         nextState = EMPTY;
            end
            WAIT_MEM: begin
                fwd_pending = destLive;
                if (flush)           nextState = mem_rvalid ? EMPTY : DRAIN;
                else if (mem_rvalid) begin
                    nextState = COMMIT;
                    loadLatch = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_rvalid) nextState = EMPTY;
            end
            default: nextState = EMPTY;
        endcase
        if (state == COMMIT) begin
            retire = 1'b1;
            rf_we  = destLive;
        end
        fwd_valid = rf_we;
        rf_waddr  = stgAddr;
        rf_wdata  = stgData;
        fwd_addr  = stgAddr;
        fwd_data  = stgData;
    end

    // MEM/WB stage register; data slot is later overwritten by the aligned load word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stgWe   <= 1'b0;
            stgAddr <= '0;
            stgOp   <= MOP_WORD;
            stgOff  <= '0;
            stgData <= '0;
        end else if (capture) begin
            stgWe   <= in_reg_we;
            stgAddr <= in_reg_addr;
            stgOp   <= in_mem_op;
            stgOff  <= in_byte_off;
            stgData <= (in_wb_sel == WB_SEL_LINK) ? in_link_addr : in_alu_result;
        end else if (loadLatch) begin
            stgData <= alignedData;
        end
    end

`ifdef WB_PERF_CNT_EN
    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      perf_retired <= '0;
        else if (retire) perf_retired <= perf_retired + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed plus randomized bench for wb_commit_stage against a behavioural load/commit model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_commit_stage;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [1:0]  in_wb_sel;
    logic        in_reg_we;
    logic [4:0]  in_reg_addr;
    logic [31:0] in_alu_result, in_link_addr;
    logic [2:0]  in_mem_op;
    logic [1:0]  in_byte_off;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_pending, fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        retire;
`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_retired;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int expRetired  = 0;

    wb_commit_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wb_sel     (in_wb_sel),
        .in_reg_we     (in_reg_we),
        .in_reg_addr   (in_reg_addr),
        .in_alu_result (in_alu_result),
        .in_link_addr  (in_link_addr),
        .in_mem_op     (in_mem_op),
        .in_byte_off   (in_byte_off),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_pending   (fwd_pending),
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .retire        (retire)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_retired  (perf_retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load result from the architectural rule: shift the word, mask the lane, extend
    function automatic logic [31:0] refLoad(logic [31:0] rd, logic [2:0] op, logic [1:0] off);
        longint w, v;
        int o;
        w = rd;
        o = off;
        case (op)
            3'd1, 3'd2: begin
                v = (w >> (8 * o)) % 256;
                if (op == 3'd1 && v >= 128) v = v - 256;
            end
            3'd3, 3'd4: begin
                v = (w >> (8 * (o - o % 2))) % 65536;
                if (op == 3'd3 && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    task automatic checkCommit(string tag, logic we, logic [4:0] addr, logic [31:0] data);
        logic expWe;
        expWe = we && (addr != 5'd0);
        check({tag, ".retire"}, retire, 1);
        check({tag, ".rf_we"}, rf_we, expWe);
        check({tag, ".fwd_valid"}, fwd_valid, expWe);
        if (expWe) begin
            check({tag, ".waddr"}, rf_waddr, addr);
            check({tag, ".wdata"}, rf_wdata, data);
            check({tag, ".fwd_addr"}, fwd_addr, addr);
            check({tag, ".fwd_data"}, fwd_data, data);
        end
        expRetired++;
    endtask

    task automatic present(logic [1:0] sel, logic we, logic [4:0] addr, logic [31:0] alu,
                           logic [31:0] link, logic [2:0] op, logic [1:0] off);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_reg_we     = we;
        in_reg_addr   = addr;
        in_alu_result = alu;
        in_link_addr  = link;
        in_mem_op     = op;
        in_byte_off   = off;
    endtask

    // One isolated instruction from EMPTY through commit and back to EMPTY; called at a negedge
    task automatic runOne(string tag, logic [1:0] sel, logic we, logic [4:0] addr, logic [31:0] alu,
                          logic [31:0] link, logic [2:0] op, logic [1:0] off, logic [31:0] rdata, int lat);
        logic [31:0] exp;
        check({tag, ".ready"}, in_ready, 1);
        present(sel, we, addr, alu, link, op, off);
        @(negedge clk);
        in_valid = 1'b0;
        if (sel == 2'b01) begin
            for (int i = 0; i < lat; i++) begin
                check({tag, ".stall"}, in_ready, 0);
                check({tag, ".pending"}, fwd_pending, we && (addr != 5'd0));
                check({tag, ".noret"}, retire, 0);
                mem_rvalid = (i == lat - 1);
                mem_rdata  = (i == lat - 1) ? rdata : $urandom;
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            exp = refLoad(rdata, op, off);
        end else if (sel == 2'b10) begin
            exp = link;
        end else begin
            exp = alu;
        end
        checkCommit(tag, we, addr, exp);
        @(negedge clk);
        check({tag, ".empty"}, retire, 0);
    endtask

    logic [4:0]  b2bAddr [5];
    logic [31:0] b2bExp  [5];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wb_sel = 2'b00; in_reg_we = 1'b0;
        in_reg_addr = '0; in_alu_result = '0; in_link_addr = '0; in_mem_op = '0; in_byte_off = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst.ready", in_ready, 1);
        check("rst.rf_we", rf_we, 0);
        check("rst.retire", retire, 0);
        check("rst.pending", fwd_pending, 0);
        check("rst.fwd_valid", fwd_valid, 0);
        check("rst.waddr", rf_waddr, 0);
        check("rst.wdata", rf_wdata, 0);
        check("rst.fwd_data", fwd_data, 0);
`ifdef WB_PERF_CNT_EN
        check("rst.perf", perf_retired, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        runOne("alu", 2'b00, 1'b1, 5'd5, 32'h1234, 32'h0, 3'd0, 2'd0, 32'h0, 0);
        runOne("lb3", 2'b01, 1'b1, 5'd7, 32'h0, 32'h0, 3'd1, 2'd3, 32'h80FF7F01, 3);
        check("lb3.const", refLoad(32'h80FF7F01, 3'd1, 2'd3), 32'hFFFFFF80);
        runOne("lhu2", 2'b01, 1'b1, 5'd8, 32'h0, 32'h0, 3'd4, 2'd2, 32'h80FF7F01, 1);
        runOne("lh2", 2'b01, 1'b1, 5'd9, 32'h0, 32'h0, 3'd3, 2'd2, 32'h80FF7F01, 2);
        runOne("lbu1", 2'b01, 1'b1, 5'd10, 32'h0, 32'h0, 3'd2, 2'd1, 32'h80FF7F01, 1);
        runOne("r0", 2'b00, 1'b1, 5'd0, 32'hCAFE, 32'h0, 3'd0, 2'd0, 32'h0, 0);
        runOne("rsvsel", 2'b11, 1'b1, 5'd12, 32'h5A5A, 32'h7777, 3'd0, 2'd0, 32'h0, 0);
        runOne("ldr0", 2'b01, 1'b1, 5'd0, 32'h0, 32'h0, 3'd0, 2'd0, 32'h11223344, 2);

        // Stray rvalid while EMPTY is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray.retire", retire, 0);
        check("stray.ready", in_ready, 1);

        // Back-to-back: four ALU ops then a JAL to r31
        for (int j = 0; j < 5; j++) begin
            b2bAddr[j] = (j == 4) ? 5'd31 : 5'(j + 1);
            b2bExp[j]  = (j == 4) ? 32'h0000_1004 : 32'hA000 + 32'(j);
        end
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) checkCommit("b2b", 1'b1, b2bAddr[j-1], b2bExp[j-1]);
            if (j < 5) begin
                check("b2b.ready", in_ready, 1);
                present((j == 4) ? 2'b10 : 2'b00, 1'b1, b2bAddr[j], 32'hA000 + 32'(j),
                        32'h0000_1004, 3'd0, 2'd0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b.empty", retire, 0);

        // Flush in WAIT_MEM, orphan rvalid two cycles later
        present(2'b01, 1'b1, 5'd14, 32'h0, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("fl.pending", fwd_pending, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl.drain.ready", in_ready, 0);
        check("fl.drain.pending", fwd_pending, 0);
        check("fl.drain.retire", retire, 0);
        @(negedge clk);
        check("fl.drain2.ready", in_ready, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("fl.orphan.retire", retire, 0);
        check("fl.orphan.ready", in_ready, 1);
        runOne("fl.next", 2'b01, 1'b1, 5'd14, 32'h0, 32'h0, 3'd0, 2'd0, 32'h0BAD_F00D, 2);

        // Flush coinciding with rvalid goes straight to EMPTY
        present(2'b01, 1'b1, 5'd15, 32'h0, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        flush = 1'b0; mem_rvalid = 1'b0;
        check("flrv.retire", retire, 0);
        check("flrv.ready", in_ready, 1);

        // Flush in COMMIT: held op commits, incoming op dropped
        present(2'b00, 1'b1, 5'd16, 32'h0000_AAAA, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        present(2'b00, 1'b1, 5'd17, 32'h0000_BBBB, 32'h0, 3'd0, 2'd0);
        flush = 1'b1;
        checkCommit("flc", 1'b1, 5'd16, 32'h0000_AAAA);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flc.dropped", retire, 0);
        check("flc.ready", in_ready, 1);

        // Randomized isolated instructions
        for (int n = 0; n < 40; n++) begin
            runOne("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom_range(1, 4));
        end

`ifdef WB_PERF_CNT_EN
        check("perf.count", perf_retired, 32'(expRetired));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
